inert_cmd_seq: RTL and testbench
================================

Name: inert_cmd_seq

Overview:
- Command sequencer directly upstream of the 16-bit SPI monarch in the inertial path.
- After power-up it waits, then issues three gyro configuration writes.
- It then services data-ready interrupts by reading yaw-rate low and high bytes, and presents a signed 16-bit yaw rate with a one-clock valid strobe to the heading/integration logic.
- It drives the monarch's cmd/snd and consumes its done/resp.

Parameters:
- TMR_W, 16, width of the power-up timer; wait is 2^TMR_W clk cycles.
- CFG0, 16'h0D02, first config write (INT1 data-ready enable).
- CFG1, 16'h1160, second config write (gyro ODR/range).
- CFG2, 16'h1440, third config write (rounding).
- RD_L, 16'hA600, read yaw-rate low byte.
- RD_H, 16'hA700, read yaw-rate high byte.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- INT, input, 1, gyro data-ready, asynchronous, level, active-high.
- done, input, 1, SPI transaction complete; level-high until the next snd.
- resp, input, 16, SPI response word; valid while done=1.
- snd, output, 1, one-clk pulse that starts an SPI transaction.
- cmd, output, 16, SPI command word; registered.
- yaw_rt, output, 16, signed yaw rate {H byte, L byte}.
- vld, output, 1, one-clk pulse marking a new yaw_rt.
- init_done, output, 1, sticky high once configuration has completed.

Behaviour:
- Reset values: snd=0, cmd=0, yaw_rt=0, vld=0, init_done=0, timer=0, INT sync flops=0, state=PWR_WAIT.
- Reset asserted mid-operation aborts immediately. No further snd is issued, and power-up wait restarts from 0 when reset releases.
- INT passes through two flops before use; the FSM sees only the second flop's output (INT_s). Latency from INT to snd is at most 3 clk.
- Timer: counts up every clk while in PWR_WAIT only. Exit occurs on the cycle the timer is all-ones; the first snd comes exactly 2^TMR_W clk after reset release.
- States: PWR_WAIT, CFG0, W0, CFG1, W1, CFG2, W2, IDLE, RDL, WL, RDH, WH.
- Send states (CFGx, RDL, RDH):
  - Assert snd for exactly one clk.
  - cmd takes its new value on the same edge snd rises, and holds until the next send state.
  - The FSM unconditionally moves to the matching wait state.
- Wait states: advance only when done=1. The monarch clears done on the edge that samples snd, so the first wait cycle always sees done=0. done is ignored in every non-wait state.
- Configuration path: W0 -> CFG1, W1 -> CFG2, W2 -> IDLE. init_done is set on the W2 exit edge and never cleared except by reset.
- IDLE: if INT_s=1, go to RDL; otherwise stay.
- WL: on done, capture resp[7:0] into a low-byte holding register, then go to RDH.
- WH: on done, yaw_rt <= {resp[7:0], low holding}, and vld=1 for that single clk; then go to IDLE.
- yaw_rt and vld become visible on the same edge. yaw_rt holds until the next completed pair.
- INT_s is ignored outside IDLE, including before init_done and during a read pair. No queuing is done.
- If INT_s is still high on return to IDLE, a new pair starts on the next cycle, giving back-to-back reads with no extra gap.
- snd is never high for 2 consecutive clks, and there is at most one transaction outstanding at a time.

Test Plan:
- Reset and power-up (TMR_W=4): hold rst_n low, then release. All outputs must be 0, snd must stay low for 16 clk, and on clk 16 snd=1 with cmd=16'h0D02.
- Config sequence: monarch model returns done 32 clk after each snd. Required: exactly three snd pulses with cmd 0D02, 1160, 1440 in order. init_done rises on the clk after the third done, and no further snd occurs while INT=0.
- Read pair: after init_done, raise INT asynchronously (mid-cycle). Required: snd with cmd=A600 within 3 clk. Respond resp=16'h00CD, then expect snd with cmd=A700 and respond resp=16'h00AB. Check yaw_rt=16'hABCD and vld high exactly 1 clk.
- Interrupt masking:
  - An INT pulse before init_done produces no read.
  - An INT pulse during WL is ignored.
  - INT held high across the pair gives a second A600 snd on the clk after vld.
- Reset mid-read: pull rst_n low during WH. Required: yaw_rt=0, vld and snd stay low, and after release the bench sees a fresh 16 clk wait followed by cmd=0D02.
- Spurious done: pulse done high in IDLE and in PWR_WAIT. Required: no state change, no snd, and yaw_rt unchanged.

Source files
------------

// File: rtl/inert_cmd_seq.sv
// Gyro command sequencer: power-up wait, three config writes, then a yaw-rate L/H read pair per data-ready.
// snd/cmd are registered on entry to a send state (INT to snd <= 3 clk); one SPI transaction outstanding, stalls on done.
module inert_cmd_seq #(
    parameter int          TMR_W = 16,
    parameter logic [15:0] CFG0  = 16'h0D02,
    parameter logic [15:0] CFG1  = 16'h1160,
    parameter logic [15:0] CFG2  = 16'h1440,
    parameter logic [15:0] RD_L  = 16'hA600,
    parameter logic [15:0] RD_H  = 16'hA700
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        snd,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        init_done
);

    typedef enum logic [3:0] {
        S_PWR_WAIT, S_CFG0, S_W0, S_CFG1, S_W1, S_CFG2, S_W2,
        S_IDLE, S_RDL, S_WL, S_RDH, S_WH
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer;
    logic               int_meta, int_s;
    logic [7:0]         lo_byte;
    logic               snd_nxt;
    logic [15:0]        cmd_nxt;
    logic               lo_ld, yaw_ld, init_set;

    // snd/cmd are computed for the state being entered, so both rise with the send state itself
    always_comb begin
        state_nxt = state;
        snd_nxt   = 1'b0;
        cmd_nxt   = cmd;
        lo_ld     = 1'b0;
        yaw_ld    = 1'b0;
        init_set  = 1'b0;
        case (state)
            S_PWR_WAIT: if (&timer) begin
                state_nxt = S_CFG0;
                snd_nxt   = 1'b1;
                cmd_nxt   = CFG0;
            end
            S_CFG0: state_nxt = S_W0;
            S_W0: if (done) begin
                state_nxt = S_CFG1;
                snd_nxt   = 1'b1;
                cmd_nxt   = CFG1;
            end
            S_CFG1: state_nxt = S_W1;
            S_W1: if (done) begin
                state_nxt = S_CFG2;
                snd_nxt   = 1'b1;
                cmd_nxt   = CFG2;
            end
            S_CFG2: state_nxt = S_W2;
            S_W2: if (done) begin
                state_nxt = S_IDLE;
                init_set  = 1'b1;
            end
            S_IDLE: if (int_s) begin
                state_nxt = S_RDL;
                snd_nxt   = 1'b1;
                cmd_nxt   = RD_L;
            end
            S_RDL: state_nxt = S_WL;
            S_WL: if (done) begin
                state_nxt = S_RDH;
                snd_nxt   = 1'b1;
                cmd_nxt   = RD_H;
                lo_ld     = 1'b1;
            end
            S_RDH: state_nxt = S_WH;
            S_WH: if (done) begin
                state_nxt = S_IDLE;
                yaw_ld    = 1'b1;
            end
            default: state_nxt = S_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PWR_WAIT;
            timer     <= '0;
            int_meta  <= 1'b0;
            int_s     <= 1'b0;
            lo_byte   <= 8'h00;
            snd       <= 1'b0;
            cmd       <= 16'h0000;
            yaw_rt    <= 16'h0000;
            vld       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            int_meta <= INT;
            int_s    <= int_meta;
            snd      <= snd_nxt;
            cmd      <= cmd_nxt;
            vld      <= yaw_ld;
            if (state == S_PWR_WAIT) timer <= timer + TMR_W'(1);
            if (lo_ld)               lo_byte <= resp[7:0];
            if (yaw_ld)              yaw_rt <= {resp[7:0], lo_byte};
            if (init_set)            init_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inert_cmd_seq.sv
// Randomised + directed bench for inert_cmd_seq against a transaction-level sequencer model.
module tb_inert_cmd_seq;
    localparam int          TW = 4;
    localparam int          PW = 1 << TW;
    localparam logic [15:0] C0 = 16'h0D02, C1 = 16'h1160, C2 = 16'h1440;
    localparam logic [15:0] RL = 16'hA600, RH = 16'hA700;

    logic        clk = 1'b0;
    logic        rst_n, int_in, spur, done_mon, done;
    logic [15:0] resp;
    logic        snd, vld, init_done;
    logic [15:0] cmd, yaw_rt;

    assign done = done_mon | spur;

    inert_cmd_seq #(.TMR_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .INT(int_in), .done(done), .resp(resp),
        .snd(snd), .cmd(cmd), .yaw_rt(yaw_rt), .vld(vld), .init_done(init_done)
    );

    initial forever #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 = power-up wait, 1 = transaction outstanding, 2 = idle.
    // tx index: 0..2 config writes, 3 low-byte read, 4 high-byte read.
    int          m_phase, m_tx, m_pcnt;
    bit          m_just;
    logic        m_i1, m_i2, m_snd, m_vld, m_init;
    logic [15:0] m_cmd, m_yaw;
    logic [7:0]  m_lo;

    task automatic m_reset();
        m_phase = 0; m_tx = 0; m_pcnt = 0; m_just = 0;
        m_i1 = 0; m_i2 = 0; m_snd = 0; m_vld = 0; m_init = 0;
        m_cmd = 0; m_yaw = 0; m_lo = 0;
    endtask

    task automatic m_send(input logic [15:0] c, input int t);
        m_snd = 1; m_cmd = c; m_tx = t; m_phase = 1; m_just = 1;
    endtask

    task automatic m_complete();
        case (m_tx)
            0: m_send(C1, 1);
            1: m_send(C2, 2);
            2: begin m_init = 1; m_phase = 2; end
            3: begin m_lo = resp[7:0]; m_send(RH, 4); end
            default: begin m_yaw = {resp[7:0], m_lo}; m_vld = 1; m_phase = 2; end
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else begin
                m_snd = 0; m_vld = 0;
                case (m_phase)
                    0: begin m_pcnt++; if (m_pcnt == PW) m_send(C0, 0); end
                    1: if (m_just) m_just = 0; else if (done) m_complete();
                    default: if (m_i2) m_send(RL, 3);
                endcase
                // INT becomes visible to the sequencer two edges after it is sampled
                m_i2 = m_i1; m_i1 = int_in;
            end
        end
    end

    // Monitor, per-cycle compare and SPI monarch model, all on the falling edge.
    int          cyc, rel, mcnt, mon_lat, init_rise, done_cyc, vld_cnt;
    bit          rand_mode, prev_snd, prev_init;
    logic [15:0] resp_l, resp_h, last_cmd;
    logic [15:0] sent_q[$];

    initial begin
        cyc = 0; rel = 0; mcnt = 0; init_rise = 0; done_cyc = 0; vld_cnt = 0;
        prev_snd = 0; prev_init = 0; done_mon = 0; resp = 0; last_cmd = 0;
        forever begin
            @(negedge clk);
            cyc++;
            rel = rst_n ? rel + 1 : 0;
            check("cycle", {snd, cmd, yaw_rt, vld, init_done}, {m_snd, m_cmd, m_yaw, m_vld, m_init});
            if (snd && rst_n) check("snd_gap", prev_snd, 0);
            if (init_done && !prev_init) init_rise = cyc;
            if (vld) vld_cnt++;
            prev_snd  = snd;
            prev_init = init_done;
            if (!rst_n) begin
                done_mon = 0; mcnt = 0;
            end else if (snd) begin
                done_mon = 0;
                last_cmd = cmd;
                sent_q.push_back(cmd);
                mcnt = rand_mode ? $urandom_range(1, 8) : mon_lat;
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    done_mon = 1;
                    done_cyc = cyc;
                    if (rand_mode)         resp = 16'($urandom);
                    else if (last_cmd == RL) resp = resp_l;
                    else if (last_cmd == RH) resp = resp_h;
                    else                     resp = 16'h0000;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_snd(input int lim, input string name);
        bit ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk); #1;
            if (snd) ok = 1;
        end
        check(name, ok, 1);
    endtask

    // sel 0 waits for vld, sel 1 for init_done
    task automatic wait_sig(input int sel, input int lim, input string name);
        bit ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk); #1;
            if ((sel == 0) ? vld : init_done) ok = 1;
        end
        check(name, ok, 1);
    endtask

    task automatic power_up(input string tag);
        wait_snd(2 * PW + 4, {tag, "_first_snd"});
        check({tag, "_first_rel"}, rel, PW);
        check({tag, "_first_cmd"}, cmd, C0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; int_in = 0; spur = 0; rand_mode = 0; mon_lat = 32;
        resp_l = 0; resp_h = 0;
        tick(3);
        check("reset_outs", {snd, cmd, yaw_rt, vld, init_done}, 0);
        #1 rst_n = 1;

        // spurious done during power-up wait must not disturb the timer
        tick(1); spur = 1; tick(1); spur = 0;
        power_up("pwr");

        // INT pulse while configuring produces no read
        tick(5); int_in = 1; tick(3); int_in = 0;
        wait_sig(1, 300, "init_done_wait");
        check("cfg_count", sent_q.size(), 3);
        check("cfg_cmds", {sent_q[0], sent_q[1], sent_q[2]}, {C0, C1, C2});
        check("init_after_done", init_rise - done_cyc, 1);

        // quiet idle, spurious done included
        tick(10); spur = 1; tick(2); spur = 0; tick(40);
        check("idle_no_snd", sent_q.size(), 3);
        check("idle_yaw", yaw_rt, 0);

        // directed read pair, INT raised mid-cycle; a WL-time INT pulse is ignored
        resp_l = 16'h00CD; resp_h = 16'h00AB;
        #2 int_in = 1;
        wait_snd(3, "int_latency");
        check("rdl_cmd", cmd, RL);
        int_in = 0;
        tick(5); int_in = 1; tick(3); int_in = 0;
        wait_sig(0, 120, "pair_vld_wait");
        check("pair_yaw", yaw_rt, 16'hABCD);
        check("pair_cmds", {sent_q[3], sent_q[4]}, {RL, RH});
        tick(1);
        check("vld_width", vld, 0);
        tick(10);
        check("wl_int_ignored", sent_q.size(), 5);

        // INT held across a pair restarts on the clk after vld
        int_in = 1;
        wait_sig(0, 120, "held_vld_wait");
        tick(1);
        check("b2b_snd", {snd, cmd}, {1'b1, RL});
        int_in = 0;
        wait_sig(0, 120, "b2b_vld_wait");

        // reset asserted while waiting for the high byte
        int_in = 1;
        wait_snd(5, "rst_rdl");
        int_in = 0;
        wait_snd(60, "rst_rdh");
        check("rst_rdh_cmd", cmd, RH);
        tick(5); rst_n = 0;
        tick(1);
        check("rst_mid", {yaw_rt, vld, snd}, 0);
        tick(3);
        check("rst_hold", {vld, snd}, 0);
        #1 rst_n = 1;
        power_up("rerun");

        // randomised traffic with a mid-run reset
        rand_mode = 1;
        wait_sig(1, 200, "rand_init");
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #3;
            if ($urandom_range(0, 5) == 0) int_in = ~int_in;
            if (i == 1000) rst_n = 0;
            if (i == 1003) rst_n = 1;
        end
        check("rand_activity", vld_cnt > 20, 1);
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
